// File: rtl/rename_pkg.sv
// rename_pkg: shared types and sizing for the register-rename stage
package rename_pkg;
  localparam int NUM_ARCH = 16;
  localparam int NUM_PHYS = 32;
  localparam int TAG_W = $clog2(NUM_PHYS);
  localparam int FLAG_W = 8;
  localparam int FUID_W = 4;
  localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0] count_t;
  typedef logic [3:0] arch_t;
  localparam count_t FREE_CNT = count_t'(NUM_FREE);
  typedef struct packed {
    arch_t arch;
    logic  used;
  } regfield_t;
  typedef struct packed {
    tag_t [1:0]        src_tag;
    logic [1:0]        src_used;
    tag_t              dst_tag;
    tag_t              old_dst_tag;
    logic              dst_used;
    logic [FLAG_W-1:0] flags;
    logic [FUID_W-1:0] fuid;
  } renamed_uop_t;
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical tags with flush rewind
module rename_free_list
  import rename_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pop,
  input  logic   push,
  input  logic   flush,
  input  tag_t   push_tag,
  output tag_t   head_tag,
  output count_t count
);
  tag_t mem [NUM_PHYS];
  tag_t head, tail, tail_next;
  assign tail_next = tail + tag_t'(push);
  assign head_tag = mem[head];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) mem[i] <= i < NUM_FREE ? tag_t'(i + NUM_ARCH) : '0;
      head <= '0;
      tail <= tag_t'(NUM_FREE);
      count <= FREE_CNT;
    end else begin
      if (push) mem[tail] <= push_tag;
      tail <= tail_next;
      head <= flush ? tail_next - tag_t'(NUM_FREE) : head + tag_t'(pop);
      count <= flush ? FREE_CNT : count + count_t'(push) - count_t'(pop);
    end
  assert property (@(posedge clk) disable iff (rst) push |-> count < FREE_CNT);
endmodule

// File: rtl/rename_stage.sv
// rename_stage: speculative RAT + free-list renaming with committed RAT recovery
module rename_stage
  import rename_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0][4:0]         in_readregs,
  input  logic [4:0]              in_writereg,
  input  logic [FLAG_W-1:0]       in_flags,
  input  logic [FUID_W-1:0]       in_fuid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0][TAG_W-1:0]   out_src_tag,
  output logic [1:0]              out_src_used,
  output logic [TAG_W-1:0]        out_dst_tag,
  output logic [TAG_W-1:0]        out_old_dst_tag,
  output logic                    out_dst_used,
  output logic [FLAG_W-1:0]       out_flags,
  output logic [FUID_W-1:0]       out_fuid,
  input  logic                    commit_valid,
  input  logic [3:0]              commit_arch,
  input  logic [TAG_W-1:0]        commit_tag,
  input  logic [TAG_W-1:0]        commit_old_tag,
  input  logic                    flush
);
  tag_t rat [NUM_ARCH];
  tag_t crat [NUM_ARCH];
  regfield_t [1:0] src;
  regfield_t dst;
  renamed_uop_t uop, nxt;
  tag_t head_tag;
  count_t count;
  logic fire, alloc;
  assign src = in_readregs;
  assign dst = in_writereg;
  assign in_ready = !flush && (!out_valid || out_ready) && (!dst.used || count != '0);
  assign fire = in_valid && in_ready;
  assign alloc = fire && dst.used;
  rename_free_list u_fl (
    .clk(clk),
    .rst(rst),
    .pop(alloc),
    .push(commit_valid),
    .flush(flush),
    .push_tag(commit_old_tag),
    .head_tag(head_tag),
    .count(count)
  );
  always_comb begin
    nxt.src_used = {src[1].used, src[0].used};
    nxt.src_tag[0] = src[0].used ? rat[src[0].arch] : '0;
    nxt.src_tag[1] = src[1].used ? rat[src[1].arch] : '0;
    nxt.dst_used = dst.used;
    nxt.dst_tag = dst.used ? head_tag : '0;
    nxt.old_dst_tag = dst.used ? rat[dst.arch] : '0;
    nxt.flags = in_flags;
    nxt.fuid = in_fuid;
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i] <= tag_t'(i);
        crat[i] <= tag_t'(i);
      end
    end else begin
      if (commit_valid) crat[commit_arch] <= commit_tag;
      if (flush)
        for (int i = 0; i < NUM_ARCH; i++)
          rat[i] <= commit_valid && commit_arch == arch_t'(i) ? commit_tag : crat[i];
      else if (alloc)
        rat[dst.arch] <= head_tag;
    end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      uop <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      uop <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  assign out_src_tag = uop.src_tag;
  assign out_src_used = uop.src_used;
  assign out_dst_tag = uop.dst_tag;
  assign out_old_dst_tag = uop.old_dst_tag;
  assign out_dst_used = uop.dst_used;
  assign out_flags = uop.flags;
  assign out_fuid = uop.fuid;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: scoreboard bench for rename_stage with a reference rename model
module tb_rename_stage;
  import rename_pkg::*;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_dst_used;
  logic commit_valid, flush;
  logic [1:0][4:0] in_readregs;
  logic [4:0] in_writereg;
  logic [FLAG_W-1:0] in_flags, out_flags;
  logic [FUID_W-1:0] in_fuid, out_fuid;
  logic [1:0][TAG_W-1:0] out_src_tag;
  logic [1:0] out_src_used;
  logic [TAG_W-1:0] out_dst_tag, out_old_dst_tag, commit_tag, commit_old_tag;
  logic [3:0] commit_arch;
  typedef struct {
    logic [3:0] a;
    tag_t t;
    tag_t o;
  } inf_t;
  int n_checks = 0;
  int n_fail = 0;
  tag_t m_rat [NUM_ARCH];
  tag_t m_crat [NUM_ARCH];
  tag_t m_fl [NUM_PHYS];
  int m_head, m_tail, m_count;
  logic m_ov;
  renamed_uop_t m_last;
  renamed_uop_t sbq [$];
  inf_t inflight [$];
  rename_stage dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_readregs(in_readregs),
    .in_writereg(in_writereg),
    .in_flags(in_flags),
    .in_fuid(in_fuid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src_tag(out_src_tag),
    .out_src_used(out_src_used),
    .out_dst_tag(out_dst_tag),
    .out_old_dst_tag(out_old_dst_tag),
    .out_dst_used(out_dst_used),
    .out_flags(out_flags),
    .out_fuid(out_fuid),
    .commit_valid(commit_valid),
    .commit_arch(commit_arch),
    .commit_tag(commit_tag),
    .commit_old_tag(commit_old_tag),
    .flush(flush)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic renamed_uop_t got_uop();
    renamed_uop_t u;
    u.src_tag = out_src_tag;
    u.src_used = out_src_used;
    u.dst_tag = out_dst_tag;
    u.old_dst_tag = out_old_dst_tag;
    u.dst_used = out_dst_used;
    u.flags = out_flags;
    u.fuid = out_fuid;
    return u;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_readregs = '0;
    in_writereg = '0;
    in_flags = '0;
    in_fuid = '0;
    out_ready = 1'b0;
    commit_valid = 1'b0;
    commit_arch = '0;
    commit_tag = '0;
    commit_old_tag = '0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_ARCH; i++) begin
      m_rat[i] = tag_t'(i);
      m_crat[i] = tag_t'(i);
    end
    for (int i = 0; i < NUM_PHYS; i++) m_fl[i] = i < NUM_FREE ? tag_t'(i + NUM_ARCH) : '0;
    m_head = 0;
    m_tail = NUM_FREE;
    m_count = NUM_FREE;
    m_ov = 1'b0;
    m_last = '0;
    sbq.delete();
    inflight.delete();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_uop", got_uop(), '0);
  endtask
  task automatic step(input logic v, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] w,
                      input logic ordy, input logic cv, input logic [3:0] ca, input tag_t ct,
                      input tag_t cot, input logic fl, output logic rdy);
    renamed_uop_t e;
    logic exp_rdy, fire;
    in_valid = v;
    in_readregs[0] = ra;
    in_readregs[1] = rb;
    in_writereg = w;
    in_flags = FLAG_W'($urandom);
    in_fuid = FUID_W'($urandom);
    out_ready = ordy;
    commit_valid = cv;
    commit_arch = ca;
    commit_tag = ct;
    commit_old_tag = cot;
    flush = fl;
    #1;
    rdy = in_ready;
    exp_rdy = !fl && (!m_ov || ordy) && (!w[0] || m_count != 0);
    chk("in_ready", rdy, exp_rdy);
    fire = v && exp_rdy;
    e.src_tag[0] = ra[0] ? m_rat[ra[4:1]] : '0;
    e.src_tag[1] = rb[0] ? m_rat[rb[4:1]] : '0;
    e.src_used = {rb[0], ra[0]};
    e.dst_tag = w[0] ? m_fl[m_head] : '0;
    e.old_dst_tag = w[0] ? m_rat[w[4:1]] : '0;
    e.dst_used = w[0];
    e.flags = in_flags;
    e.fuid = in_fuid;
    if (fire) sbq.push_back(e);
    if (cv) begin
      m_crat[ca] = ct;
      m_fl[m_tail] = cot;
      m_tail = (m_tail + 1) % NUM_PHYS;
      m_count++;
    end
    if (fl) begin
      m_rat = m_crat;
      m_head = (m_tail + NUM_PHYS - NUM_FREE) % NUM_PHYS;
      m_count = NUM_FREE;
      m_ov = 1'b0;
      inflight.delete();
    end else begin
      if (fire && w[0]) begin
        m_rat[w[4:1]] = m_fl[m_head];
        inflight.push_back('{a: w[4:1], t: m_fl[m_head], o: e.old_dst_tag});
        m_head = (m_head + 1) % NUM_PHYS;
        m_count--;
      end
      m_ov = fire || (m_ov && !ordy);
    end
    @(posedge clk);
    #1;
    if (fire) m_last = sbq.pop_front();
    chk("out_valid", out_valid, m_ov);
    chk("uop", got_uop(), m_last);
  endtask
  initial begin
    logic rdy, cv, fl;
    inf_t c;
    do_reset();
    step(1, 5'b00011, 5'b00101, 5'b00111, 1, 0, 0, 0, 0, 0, rdy);
    chk("t1_dst", out_dst_tag, 16);
    chk("t1_old", out_old_dst_tag, 3);
    chk("t1_src0", out_src_tag[0], 1);
    chk("t1_src1", out_src_tag[1], 2);
    step(1, 5'b00111, 5'b00000, 5'b00111, 1, 0, 0, 0, 0, 0, rdy);
    chk("b2b_src", out_src_tag[0], 16);
    chk("b2b_dst", out_dst_tag, 17);
    chk("b2b_old", out_old_dst_tag, 16);
    do_reset();
    for (int i = 0; i < NUM_ARCH; i++) step(1, 0, 0, {4'(i), 1'b1}, 1, 0, 0, 0, 0, 0, rdy);
    step(1, 0, 0, 5'b00111, 1, 0, 0, 0, 0, 0, rdy);
    chk("exhaust_ready", rdy, 1'b0);
    step(1, 0, 0, 5'b00111, 1, 1, 4'd3, 5'd19, 5'd3, 0, rdy);
    chk("commit_no_alloc", rdy, 1'b0);
    step(1, 0, 0, 5'b01001, 1, 0, 0, 0, 0, 0, rdy);
    chk("reuse_tag", out_dst_tag, 3);
    chk("reuse_old", out_old_dst_tag, 20);
    do_reset();
    step(1, 5'b00011, 0, 5'b00011, 1, 0, 0, 0, 0, 0, rdy);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'b00011, 0, 5'b00101, 0, 0, 0, 0, 0, 0, rdy);
      chk("stall_ready", rdy, 1'b0);
      chk("stall_dst_hold", out_dst_tag, 16);
    end
    step(1, 5'b00011, 0, 5'b00101, 1, 0, 0, 0, 0, 0, rdy);
    chk("stall_src", out_src_tag[0], 16);
    chk("stall_dst", out_dst_tag, 17);
    do_reset();
    step(1, 0, 0, 5'b00011, 1, 0, 0, 0, 0, 0, rdy);
    step(1, 0, 0, 5'b00101, 1, 0, 0, 0, 0, 0, rdy);
    step(1, 0, 0, 5'b00111, 1, 0, 0, 0, 0, 0, rdy);
    step(1, 0, 0, 5'b01001, 1, 1, 4'd1, 5'd16, 5'd1, 1, rdy);
    chk("flush_ready", rdy, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    step(1, 5'b00011, 5'b00101, 5'b01001, 1, 0, 0, 0, 0, 0, rdy);
    chk("flush_r1", out_src_tag[0], 16);
    chk("flush_r2", out_src_tag[1], 2);
    chk("flush_alloc0", out_dst_tag, 17);
    step(1, 5'b00111, 0, 5'b01011, 1, 0, 0, 0, 0, 0, rdy);
    chk("flush_r3", out_src_tag[0], 3);
    chk("flush_alloc1", out_dst_tag, 18);
    do_reset();
    for (int i = 0; i < NUM_FREE - 1; i++) step(1, 0, 0, {4'(i), 1'b1}, 1, 0, 0, 0, 0, 0, rdy);
    for (int i = 0; i < 40; i++) begin
      c = inflight.pop_front();
      step(1, 5'($urandom), 5'($urandom), {4'($urandom), 1'b1}, 1, 1, c.a, c.t, c.o, 0, rdy);
      chk("cnt1_ready", rdy, 1'b1);
    end
    for (int k = 0; k < 400; k++) begin
      cv = inflight.size() > 0 && $urandom_range(1) == 1;
      c = '{a: '0, t: '0, o: '0};
      if (cv) c = inflight.pop_front();
      fl = $urandom_range(15) == 0;
      step(1'($urandom_range(1)), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom_range(3) != 0, cv, c.a, c.t, c.o, fl, rdy);
    end
    step(1, 0, 0, 5'b00011, 0, 0, 0, 0, 0, 0, rdy);
    do_reset();
    step(1, 5'b00011, 5'b00101, 5'b00111, 1, 0, 0, 0, 0, 0, rdy);
    chk("post_rst_dst", out_dst_tag, 16);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
